vga_frame_reader: RTL and testbench



---
 rtl/vga_frame_reader_pkg.sv | 38 +++
 rtl/vga_frame_reader_timing_gen.sv | 66 ++++++
 rtl/vga_frame_reader.sv | 145 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_reader_pkg.sv
// Shared constants and types for the read side of the ping-pong frame buffer:
// default 640x480@60 timing, window geometry, RGB565 colours and the reader FSM state.
package vga_frame_reader_pkg;

  localparam int unsigned CntW = 10;

  localparam int unsigned DefHAct  = 640;
  localparam int unsigned DefHFp   = 16;
  localparam int unsigned DefHSync = 96;
  localparam int unsigned DefHBp   = 48;
  localparam int unsigned DefVAct  = 480;
  localparam int unsigned DefVFp   = 10;
  localparam int unsigned DefVSync = 2;
  localparam int unsigned DefVBp   = 33;

  localparam int unsigned DefWinX  = 160;
  localparam int unsigned DefWinY  = 140;
  localparam int unsigned DefWinW  = 320;
  localparam int unsigned DefWinH  = 200;
  localparam int unsigned DefRdLat = 2;

  localparam logic [15:0] ColorFg     = 16'hFFFF;
  localparam logic [15:0] ColorBg     = 16'h0000;
  localparam logic [15:0] ColorBorder = 16'h001F;
  localparam logic [15:0] ColorBlank  = 16'h0000;

  typedef enum logic [0:0] {StWaitFirst, StRun} state_e;

  // Compare first so the unsigned offset subtraction can never wrap.
  function automatic logic in_span(input logic [CntW-1:0] pos, input logic [CntW-1:0] lo,
                                   input logic [CntW-1:0] len);
    logic [CntW-1:0] off;
    if (pos < lo) return 1'b0;
    off = pos - lo;
    return off < len;
  endfunction

endpackage

// File: rtl/vga_frame_reader_timing_gen.sv
// Free-running VGA raster counters with raw (undelayed) syncs, active flag and the
// frame-boundary strobe on the last pixel of the last line.
module vga_frame_reader_timing_gen
  import vga_frame_reader_pkg::*;
#(
  parameter int unsigned HAct  = DefHAct,
  parameter int unsigned HFp   = DefHFp,
  parameter int unsigned HSync = DefHSync,
  parameter int unsigned HBp   = DefHBp,
  parameter int unsigned VAct  = DefVAct,
  parameter int unsigned VFp   = DefVFp,
  parameter int unsigned VSync = DefVSync,
  parameter int unsigned VBp   = DefVBp
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [CntW-1:0] hcnt_o,
  output logic [CntW-1:0] vcnt_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            active_o,
  output logic            fb_o
);

  localparam int unsigned HTotal = HAct + HFp + HSync + HBp;
  localparam int unsigned VTotal = VAct + VFp + VSync + VBp;

  localparam logic [CntW-1:0] HLast    = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VLast    = CntW'(VTotal - 1);
  localparam logic [CntW-1:0] HActEnd  = CntW'(HAct);
  localparam logic [CntW-1:0] VActEnd  = CntW'(VAct);
  localparam logic [CntW-1:0] HSyncLo  = CntW'(HAct + HFp);
  localparam logic [CntW-1:0] HSyncHi  = CntW'(HAct + HFp + HSync);
  localparam logic [CntW-1:0] VSyncLo  = CntW'(VAct + VFp);
  localparam logic [CntW-1:0] VSyncHi  = CntW'(VAct + VFp + VSync);

  logic [CntW-1:0] hcnt_q, hcnt_d;
  logic [CntW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + CntW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;
  assign hsync_o  = !((hcnt_q >= HSyncLo) && (hcnt_q < HSyncHi));
  assign vsync_o  = !((vcnt_q >= VSyncLo) && (vcnt_q < VSyncHi));
  assign active_o = (hcnt_q < HActEnd) && (vcnt_q < VActEnd);
  assign fb_o     = (hcnt_q == HLast) && (vcnt_q == VLast);

endmodule

// File: rtl/vga_frame_reader.sv
// Read side of the ping-pong frame buffer: fetches the 1-bit window from the bank not being
// written, drives RGB565 plus syncs, and swaps banks with the writer at frame boundaries.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int unsigned HAct  = DefHAct,
  parameter int unsigned HFp   = DefHFp,
  parameter int unsigned HSync = DefHSync,
  parameter int unsigned HBp   = DefHBp,
  parameter int unsigned VAct  = DefVAct,
  parameter int unsigned VFp   = DefVFp,
  parameter int unsigned VSync = DefVSync,
  parameter int unsigned VBp   = DefVBp,
  parameter int unsigned WinX  = DefWinX,
  parameter int unsigned WinY  = DefWinY,
  parameter int unsigned WinW  = DefWinW,
  parameter int unsigned WinH  = DefWinH,
  parameter int unsigned RdLat = DefRdLat
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_end,
  input  logic        din,
  output logic [15:0] rd_addr,
  output logic        rd_en,
  output logic        rd_end,
  output logic        rd_addr_sel,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [15:0] vga_rgb
);

  // One registered read stage plus the RAM latency.
  localparam int unsigned Lat = 1 + RdLat;

  localparam logic [15:0]     AddrLast = 16'(WinW * WinH - 1);
  localparam logic [CntW-1:0] WinXC    = CntW'(WinX);
  localparam logic [CntW-1:0] WinYC    = CntW'(WinY);
  localparam logic [CntW-1:0] WinWC    = CntW'(WinW);
  localparam logic [CntW-1:0] WinHC    = CntW'(WinH);

  logic [CntW-1:0] hcnt, vcnt;
  logic            hsync_raw, vsync_raw, active_raw, fb;

  vga_frame_reader_timing_gen #(
    .HAct  (HAct),
    .HFp   (HFp),
    .HSync (HSync),
    .HBp   (HBp),
    .VAct  (VAct),
    .VFp   (VFp),
    .VSync (VSync),
    .VBp   (VBp)
  ) u_timing (
    .clk_i    (clk),
    .rst_i    (rst),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .hsync_o  (hsync_raw),
    .vsync_o  (vsync_raw),
    .active_o (active_raw),
    .fb_o     (fb)
  );

  state_e         state_q, state_d;
  logic           sel_q, sel_d;
  logic           rd_end_q, rd_end_d;
  logic [15:0]    addr_q, addr_d;
  logic [Lat-1:0] hs_q, hs_d, vs_q, vs_d, act_q, act_d, win_q, win_d, rd_q, rd_d;
  logic           in_win;

  always_comb begin
    in_win = active_raw && in_span(hcnt, WinXC, WinWC) && in_span(vcnt, WinYC, WinHC);

    state_d  = state_q;
    sel_d    = sel_q;
    rd_end_d = 1'b0;
    // Swap only in the blanking-time FB cycle so no read is in flight across it.
    if (fb && wr_end) begin
      state_d  = StRun;
      sel_d    = ~sel_q;
      rd_end_d = 1'b1;
    end

    hs_d  = {hs_q[Lat-2:0], hsync_raw};
    vs_d  = {vs_q[Lat-2:0], vsync_raw};
    act_d = {act_q[Lat-2:0], active_raw};
    win_d = {win_q[Lat-2:0], in_win};
    rd_d  = {rd_q[Lat-2:0], (state_q == StRun) && in_win};

    // rd_q[0] is the live rd_en: the current address is consumed this cycle.
    addr_d = addr_q;
    if (fb) begin
      addr_d = '0;
    end else if (rd_q[0]) begin
      addr_d = (addr_q == AddrLast) ? '0 : addr_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StWaitFirst;
      sel_q    <= 1'b0;
      rd_end_q <= 1'b0;
      addr_q   <= '0;
      hs_q     <= '1;
      vs_q     <= '1;
      act_q    <= '0;
      win_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rd_end_q <= rd_end_d;
      addr_q   <= addr_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      act_q    <= act_d;
      win_q    <= win_d;
      rd_q     <= rd_d;
    end
  end

  assign rd_en       = rd_q[0];
  assign rd_addr     = addr_q;
  assign rd_end      = rd_end_q;
  assign rd_addr_sel = sel_q;
  assign vga_hsync   = hs_q[Lat-1];
  assign vga_vsync   = vs_q[Lat-1];

  // Delayed flags line up with din, which returns RdLat cycles after rd_en.
  always_comb begin
    vga_rgb = ColorBlank;
    if (act_q[Lat-1]) begin
      if (!win_q[Lat-1]) begin
        vga_rgb = ColorBorder;
      end else if (rd_q[Lat-1] && din) begin
        vga_rgb = ColorFg;
      end else begin
        vga_rgb = ColorBg;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a scaled-down raster; a bench RAM returns a
// checkerboard two cycles after each read, and expected pixels are queued until they emerge.
module tb_vga_frame_reader;

  localparam int unsigned HAct  = 40;
  localparam int unsigned HFp   = 4;
  localparam int unsigned HSync = 8;
  localparam int unsigned HBp   = 8;
  localparam int unsigned VAct  = 30;
  localparam int unsigned VFp   = 2;
  localparam int unsigned VSync = 2;
  localparam int unsigned VBp   = 3;
  localparam int unsigned WinX  = 10;
  localparam int unsigned WinY  = 8;
  localparam int unsigned WinW  = 20;
  localparam int unsigned WinH  = 12;
  localparam int unsigned RdLat = 2;
  localparam int unsigned Lat   = 1 + RdLat;

  localparam int unsigned HTotal = HAct + HFp + HSync + HBp;
  localparam int unsigned VTotal = VAct + VFp + VSync + VBp;
  localparam int unsigned Frame  = HTotal * VTotal;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_end = 1'b0;
  logic        din;
  logic [15:0] rd_addr, vga_rgb;
  logic        rd_en, rd_end, rd_addr_sel, vga_hsync, vga_vsync;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  vga_frame_reader #(
    .HAct  (HAct),
    .HFp   (HFp),
    .HSync (HSync),
    .HBp   (HBp),
    .VAct  (VAct),
    .VFp   (VFp),
    .VSync (VSync),
    .VBp   (VBp),
    .WinX  (WinX),
    .WinY  (WinY),
    .WinW  (WinW),
    .WinH  (WinH),
    .RdLat (RdLat)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_end      (wr_end),
    .din         (din),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_end      (rd_end),
    .rd_addr_sel (rd_addr_sel),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_rgb     (vga_rgb)
  );

  // Checkerboard keyed on the address: window pixel (0,0) is 1.
  function automatic logic ram_pat(input logic [15:0] addr);
    int unsigned x, y;
    x = int'(addr) % WinW;
    y = int'(addr) / WinW;
    return (x % 2) == (y % 2);
  endfunction

  logic ram_d1, ram_d2;
  always @(posedge clk) begin
    ram_d1 <= ram_pat(rd_addr);
    ram_d2 <= ram_d1;
  end
  assign din = ram_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_window(input int unsigned h, input int unsigned v);
    return h >= WinX && h < WinX + WinW && v >= WinY && v < WinY + WinH;
  endfunction

  // {region[1:0], hsync, vsync, rgb}; region 0 blank, 1 border, 2 window, 3 reset.
  function automatic logic [19:0] exp_pixel(input int unsigned h, input int unsigned v,
                                            input logic run);
    logic        hs, vs;
    logic [15:0] rgb;
    logic [1:0]  region;
    int unsigned x, y;
    hs = !(h >= HAct + HFp && h < HAct + HFp + HSync);
    vs = !(v >= VAct + VFp && v < VAct + VFp + VSync);
    rgb = 16'h0000;
    region = 2'd0;
    if (h < HAct && v < VAct) begin
      if (in_window(h, v)) begin
        region = 2'd2;
        x = h - WinX;
        y = v - WinY;
        rgb = (run && (x % 2) == (y % 2)) ? 16'hFFFF : 16'h0000;
      end else begin
        region = 2'd1;
        rgb = 16'h001F;
      end
    end
    return {region, hs, vs, rgb};
  endfunction

  function automatic string region_tag(input logic [1:0] r);
    case (r)
      2'd0:    return "pix_blank";
      2'd1:    return "pix_border";
      2'd2:    return "pix_window";
      default: return "pix_reset";
    endcase
  endfunction

  int unsigned m_h, m_v, m_rd_cnt, frame_rd;
  logic        m_run, m_sel;
  logic [2:0]  exp_ctl;
  logic [19:0] pix_q[$];
  logic [15:0] addr_q[$];

  // Reference raster model and scoreboard, sampled mid-cycle.
  initial begin
    logic [19:0] e;
    logic [15:0] ea;
    logic        nrd, nend, fb;
    logic        hs_prev, hs_seen, vs_prev, vs_seen;
    int unsigned hs_cnt, hs_low, vs_cnt, vs_low;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_h = 0; m_v = 0; m_rd_cnt = 0; frame_rd = 0;
        m_run = 1'b0; m_sel = 1'b0; exp_ctl = 3'b000;
        pix_q.delete();
        addr_q.delete();
        for (int i = 0; i < int'(Lat); i++) pix_q.push_back({2'd3, 1'b1, 1'b1, 16'h0000});
        hs_prev = 1'b1; hs_seen = 1'b0; hs_cnt = 0; hs_low = 0;
        vs_prev = 1'b1; vs_seen = 1'b0; vs_cnt = 0; vs_low = 0;
      end else begin
        check("ctl_rd_en_rd_end_sel", 32'({rd_en, rd_end, rd_addr_sel}), 32'(exp_ctl));
        if (rd_en) begin
          if (addr_q.size() != 0) ea = addr_q.pop_front();
          else ea = 16'hFFFF;
          check("rd_addr", 32'(rd_addr), 32'(ea));
          if (frame_rd == 0)
            check("first_rd_pos", 32'(m_h * 1024 + m_v), 32'((WinX + 1) * 1024 + WinY));
          frame_rd++;
        end

        pix_q.push_back(exp_pixel(m_h, m_v, m_run));
        e = pix_q.pop_front();
        check(region_tag(e[19:18]), 32'({vga_hsync, vga_vsync, vga_rgb}), 32'(e[17:0]));

        hs_cnt++;
        if (hs_prev && !vga_hsync) begin
          if (hs_seen) check("hsync_period", hs_cnt, HTotal);
          hs_cnt = 0; hs_seen = 1'b1; hs_low = 1;
        end else if (!hs_prev && !vga_hsync) begin
          hs_low++;
        end else if (!hs_prev && vga_hsync) begin
          check("hsync_low", hs_low, HSync);
        end
        hs_prev = vga_hsync;

        vs_cnt++;
        if (vs_prev && !vga_vsync) begin
          if (vs_seen) check("vsync_period", vs_cnt, Frame);
          vs_cnt = 0; vs_seen = 1'b1; vs_low = 1;
        end else if (!vs_prev && !vga_vsync) begin
          vs_low++;
        end else if (!vs_prev && vga_vsync) begin
          check("vsync_low", vs_low, VSync * HTotal);
        end
        vs_prev = vga_vsync;

        fb  = (m_h == HTotal - 1) && (m_v == VTotal - 1);
        nrd = m_run && in_window(m_h, m_v);
        if (nrd) begin
          addr_q.push_back(16'(m_rd_cnt));
          m_rd_cnt++;
        end
        nend = fb && wr_end;
        if (fb) begin
          check("reads_per_frame", 32'(frame_rd), m_run ? 32'(WinW * WinH) : 32'd0);
          check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
          frame_rd = 0;
          m_rd_cnt = 0;
          if (wr_end) begin
            m_sel = ~m_sel;
            m_run = 1'b1;
          end
        end
        exp_ctl = {nrd, nend, m_sel};
        m_h++;
        if (m_h == HTotal) begin
          m_h = 0;
          m_v++;
          if (m_v == VTotal) m_v = 0;
        end
      end
    end
  end

  task automatic wait_rd_end(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_end && n < 3 * int'(Frame));
    check(tag, 32'(rd_end), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, 32'({rd_addr, rd_en, rd_end, rd_addr_sel}), 32'({16'h0, 3'b000}));
    check({tag, "_vga"}, 32'({vga_hsync, vga_vsync, vga_rgb}), 32'({2'b11, 16'h0}));
  endtask

  initial begin
    logic want_sel;
    int   n;
    want_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Two idle frames, then a handshake raised mid-frame.
    repeat (2 * Frame + Frame / 2) @(posedge clk);
    #1 wr_end = 1'b1;
    wait_rd_end("swap1_rd_end");
    want_sel = ~want_sel;
    check("swap1_sel", 32'(rd_addr_sel), 32'(want_sel));
    @(posedge clk);
    #1 wr_end = 1'b0;
    @(negedge clk);
    check("rd_end_single", 32'(rd_end), 32'd0);

    // One read frame, then wr_end held high across three boundaries.
    repeat (Frame + Frame / 2) @(posedge clk);
    #1 wr_end = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_rd_end("hold_rd_end");
      want_sel = ~want_sel;
      check("hold_sel", 32'(rd_addr_sel), 32'(want_sel));
    end
    @(posedge clk);
    #1 wr_end = 1'b0;

    // Reset in the middle of the window.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_h == 25 && m_v == 15) && n < 2 * int'(Frame));
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (Frame + Frame / 2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
